// File: rtl/fp_seq_pkg.sv
// Shared types and constants for the FP adder stage sequencer.
package fp_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    S1,
    S2,
    S3,
    S4,
    DONE
  } state_t;

  localparam int NUM_STAGES = 4;

  localparam logic [NUM_STAGES-1:0] EN_NONE = 4'b0000;
  localparam logic [NUM_STAGES-1:0] EN_R1   = 4'b0001;
  localparam logic [NUM_STAGES-1:0] EN_R2   = 4'b0010;
  localparam logic [NUM_STAGES-1:0] EN_R3   = 4'b0100;
  localparam logic [NUM_STAGES-1:0] EN_R4   = 4'b1000;

endpackage

// File: rtl/fp_stage_sequencer_edge.sv
// Registered rising-edge detector used for the manual step button.
module seq_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;
  logic d_d;

  always_comb begin
    d_d = d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) d_q <= 1'b0;
    else       d_q <= d_d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/fp_stage_sequencer.sv
// Timed/manual enable sequencer for the 4-phase FP adder pipeline.
// Define FP_SEQ_OVERFLOW_HALT_EN to latch FASE4 overflow into err and halt.
module fp_stage_sequencer
  import fp_seq_pkg::*;
#(
  parameter int          CNT_W        = 26,
  parameter int unsigned DWELL_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       auto_mode,
  input  logic       step,
  input  logic       abort,
  input  logic       overflow,
  output logic [3:0] en,
  output logic [3:0] led,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [CNT_W-1:0] DWELL_LAST =
    CNT_W'(DWELL_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       en_q, en_d;
  logic [3:0]       led_q, led_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic step_rise;
  logic in_seq;
  logic adv;

  seq_edge_detect u_step_edge (
    .clk   (clk),
    .reset (reset),
    .d     (step),
    .rise  (step_rise)
  );

`ifndef FP_SEQ_OVERFLOW_HALT_EN
  logic unused_overflow;
  assign unused_overflow = overflow;
`endif

  assign in_seq = (state_q inside {S1, S2, S3, S4});
  assign adv    = in_seq &
                  (auto_mode ? (cnt_q == DWELL_LAST)
                             : step_rise);

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    en_d    = EN_NONE;
    led_d   = led_q;
    err_d   = err_q;

    if (abort) begin
      state_d = IDLE;
      led_d   = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = S1;
            en_d    = EN_R1;
            led_d   = EN_R1;
            err_d   = 1'b0;
          end
        end
        S1: begin
          if (adv) begin
            state_d = S2;
            en_d    = EN_R2;
            led_d   = led_q | EN_R2;
          end
        end
        S2: begin
          if (adv) begin
            state_d = S3;
            en_d    = EN_R3;
            led_d   = led_q | EN_R3;
          end
        end
        S3: begin
          if (adv) begin
            state_d = S4;
            en_d    = EN_R4;
            led_d   = led_q | EN_R4;
          end
        end
        S4: begin
          if (adv) begin
            state_d = DONE;
`ifdef FP_SEQ_OVERFLOW_HALT_EN
            err_d   = overflow;
`endif
          end
        end
        DONE: begin
          // A latched overflow blocks restart until abort/reset.
          if (start && !err_q) begin
            state_d = S1;
            en_d    = EN_R1;
            led_d   = EN_R1;
            err_d   = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          led_d   = '0;
          err_d   = 1'b0;
        end
      endcase

      if (in_seq && auto_mode && state_d == state_q)
        cnt_d = cnt_q + CNT_W'(1);
    end

    busy_d = (state_d inside {S1, S2, S3, S4});
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      en_q    <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign en   = en_q;
  assign led  = led_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule
